// File: rtl/sop_qualifier.sv
// Registered sum-of-products condition detector: en & (&a_in | &b_in),
// filtered by a consecutive-cycle hold qualifier and counted in a saturating counter.
module sop_qualifier #(
  parameter int WA   = 3,
  parameter int WB   = 2,
  parameter int HOLD = 4,
  parameter int CW   = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [WA-1:0] a_in,
  input  logic [WB-1:0] b_in,
  input  logic          en,
  input  logic          clr,
  output logic          y_raw,
  output logic          y,
  output logic          rise,
  output logic [CW-1:0] event_cnt,
  output logic          sat
);

  localparam int            HW        = $clog2(HOLD + 1);
  localparam logic [HW-1:0] HOLD_MAX  = HW'(HOLD);
  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD - 1);
  localparam logic [CW-1:0] CNT_MAX   = '1;

  logic          raw;
  logic          rise_cond;
  logic [HW-1:0] hcnt;

  assign raw       = en & ((&a_in) | (&b_in));
  assign rise_cond = raw & (hcnt == HOLD_LAST);

  // hcnt counts prior consecutive true samples, capped at HOLD
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hcnt <= '0;
    end else if (!raw) begin
      hcnt <= '0;
    end else if (hcnt < HOLD_MAX) begin
      hcnt <= hcnt + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      y_raw <= 1'b0;
      y     <= 1'b0;
      rise  <= 1'b0;
    end else begin
      y_raw <= raw;
      y     <= raw & (hcnt >= HOLD_LAST);
      rise  <= rise_cond;
    end
  end

  // clr outranks a coincident rise; sat latches when the count tops out
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      event_cnt <= '0;
      sat       <= 1'b0;
    end else if (clr) begin
      event_cnt <= '0;
      sat       <= 1'b0;
    end else if (rise_cond && (event_cnt != CNT_MAX)) begin
      event_cnt <= event_cnt + 1'b1;
      if (event_cnt == (CNT_MAX - 1'b1)) begin
        sat <= 1'b1;
      end
    end
  end

endmodule
